// File: rtl/debug_reg_dumper.sv
// Walks the register-file debug port (R0..R15, then PC) and streams each value as a
// framed UART 8N1 byte sequence: 0xA5, index, then the data word LSB first.
module debug_reg_dumper #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] debug_reg_out,
  input  logic [DATA_WIDTH-1:0] PC,
  output logic [3:0]            debug_reg_select,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = $clog2(NBYTES + 2);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES + 1);
  localparam logic [BYTE_W-1:0] BYTE_DATA = BYTE_W'(2);
  localparam logic [4:0]        LAST_IDX  = 5'd16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state;
  logic [4:0]            idx;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [3:0]            bit_cnt;
  logic [BYTE_W-1:0]     byte_cnt;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            cur_byte;

  // The frame buffer is shifted right after each data byte, so the next data
  // byte is always in word[7:0].
  always_comb begin
    cur_byte = 8'hA5;
    if (byte_cnt == BYTE_W'(1)) begin
      cur_byte = {3'b000, idx};
    end else if (byte_cnt >= BYTE_DATA) begin
      cur_byte = word[7:0];
    end
  end

  // start is a request only: it is accepted on an IDLE cycle and busy reports
  // acceptance from the next cycle; requests while busy are dropped, not queued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      tx               <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      debug_reg_select <= 4'd0;
      idx              <= 5'd0;
      baud_cnt         <= '0;
      bit_cnt          <= 4'd0;
      byte_cnt         <= '0;
      word             <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            state            <= SELECT;
            busy             <= 1'b1;
            idx              <= 5'd0;
            debug_reg_select <= 4'd0;
          end
        end

        SELECT: begin
          word     <= (idx == LAST_IDX) ? PC : debug_reg_out;
          tx       <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= 4'd0;
          byte_cnt <= '0;
          state    <= SEND;
        end

        SEND: begin
          if (baud_cnt != BAUD_LAST) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            if (bit_cnt != 4'd9) begin
              // Moving into bit bit_cnt+1: data bit bit_cnt, or the stop bit after d7.
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
            end else begin
              bit_cnt <= 4'd0;
              if (byte_cnt != BYTE_LAST) begin
                byte_cnt <= byte_cnt + 1'b1;
                tx       <= 1'b0;
                if (byte_cnt >= BYTE_DATA) begin
                  word <= word >> 8;
                end
              end else begin
                byte_cnt <= '0;
                tx       <= 1'b1;
                if (idx != LAST_IDX) begin
                  idx              <= idx + 5'd1;
                  debug_reg_select <= (idx >= 5'd15) ? 4'd15 : idx[3:0] + 4'd1;
                  state            <= SELECT;
                end else begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end
              end
            end
          end
        end

        FINISH: begin
          tx    <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Bench for debug_reg_dumper: a UART decoder checks every byte against an expected
// byte queue built directly from the register contents and PC.
module tb_debug_reg_dumper;

  localparam int DW          = 32;
  localparam int CPB         = 4;
  localparam int NB          = DW / 8;
  localparam int FB          = NB + 2;
  localparam int NFRAMES     = 17;
  localparam int DUMP_CYCLES = NFRAMES * (1 + FB * 10 * CPB) + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rf [16];
  logic [DW-1:0] pc;
  logic [DW-1:0] debug_reg_out;
  logic [3:0]    debug_reg_select;
  logic          tx;
  logic          busy;
  logic          done;

  // register file model: combinational read of the selected entry
  assign debug_reg_out = rf[debug_reg_select];

  debug_reg_dumper #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .debug_reg_out   (debug_reg_out),
    .PC              (pc),
    .debug_reg_select(debug_reg_select),
    .tx              (tx),
    .busy            (busy),
    .done            (done)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // UART decoder state
  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  int         mon_gap    = 0;
  logic       mon_first  = 1'b0;
  logic       mon_ok     = 1'b1;
  logic [7:0] mon_byte   = 8'h00;
  int         rx_count   = 0;
  int         done_count = 0;
  logic       prev_busy  = 1'b0;
  logic [3:0] prev_sel   = 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_expected();
    exp_q.delete();
    for (int i = 0; i < NFRAMES; i++) begin
      logic [DW-1:0] w;
      if (i < 16) w = rf[i];
      else        w = pc;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(i));
      for (int b = 0; b < NB; b++) exp_q.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 16; i++) rf[i] = $urandom();
    pc = $urandom();
  endtask

  task automatic monitor_step();
    int k;
    int exp_sel;
    if (!reset) begin
      mon_active = 1'b0;
      mon_gap    = 0;
      rx_count   = 0;
    end else begin
      if (busy && !prev_busy) rx_count = 0;
      if (done) done_count++;
      if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          mon_ok     = 1'b1;
          mon_byte   = 8'h00;
          if (rx_count % FB != 0) begin
            check("gap_in_frame", mon_gap, 0);
          end else begin
            if (rx_count > 0) check("gap_between_frames", mon_gap, 1);
            exp_sel = (rx_count / FB > 15) ? 15 : rx_count / FB;
            check("select_in_select_cycle", prev_sel, exp_sel);
          end
        end else begin
          mon_gap++;
        end
      end else begin
        mon_cnt++;
        k = mon_cnt / CPB;
        if (k == 0) begin
          if (tx !== 1'b0) mon_ok = 1'b0;
        end else if (k == 9) begin
          if (tx !== 1'b1) mon_ok = 1'b0;
        end else if (mon_cnt % CPB == 0) begin
          mon_first       = tx;
          mon_byte[k - 1] = tx;
        end else if (tx !== mon_first) begin
          mon_ok = 1'b0;
        end
        if (mon_cnt == 10 * CPB - 1) begin
          mon_active = 1'b0;
          mon_gap    = 0;
          check("byte_bit_timing", mon_ok, 1);
          check("byte_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("byte_value", mon_byte, exp_q.pop_front());
          rx_count++;
        end
      end
    end
    prev_busy = busy;
    prev_sel  = debug_reg_select;
  endtask

  // driver tasks: every step samples on the falling edge, inputs change right after
  task automatic tick();
    @(negedge clk);
    monitor_step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (done) break;
    end
  endtask

  task automatic tick_until_rx(input int target, input int budget);
    int n = 0;
    while (rx_count < target && n < budget) begin
      tick();
      n++;
    end
    check("wait_rx_count", (rx_count >= target), 1);
  endtask

  task automatic tick_until_select(input logic [3:0] s, input int budget);
    int n = 0;
    while (debug_reg_select !== s && n < budget) begin
      tick();
      n++;
    end
    check("wait_select", debug_reg_select, s);
  endtask

  initial begin
    int n;
    int dones_before;

    // reset held with start high: outputs stay idle
    for (int i = 0; i < 16; i++) rf[i] = DW'(i) * 32'h1111_1111;
    pc    = 32'h0000_0040;
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", {tx, busy, done, debug_reg_select}, {1'b1, 1'b0, 1'b0, 4'd0});
    end

    // release with start still high: first dump begins on that edge
    load_expected();
    reset = 1'b1;
    tick();
    start = 1'b0;
    check("start_after_release", {busy, tx, debug_reg_select}, {1'b1, 1'b1, 4'd0});
    run_until_done(DUMP_CYCLES + 200, n);
    check("done_latency_a", n + 1, DUMP_CYCLES);
    tick();
    check("after_done_a", {done, busy, tx}, {1'b0, 1'b0, 1'b1});
    check("queue_empty_a", exp_q.size(), 0);
    check("done_count_a", done_count, 1);

    // random dump: late change of R2 after latch, and a start pulse mid-dump
    randomize_inputs();
    load_expected();
    dones_before = done_count;
    pulse_start();
    tick_until_select(4'd2, 2000);
    tick();
    rf[2] = ~rf[2];
    tick_until_rx(5 * FB + 3, 3000);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_mid_dump", busy, 1);
    run_until_done(DUMP_CYCLES + 200, n);
    check("done_seen_b", done, 1);
    for (int i = 0; i < 60; i++) tick();
    check("queue_empty_b", exp_q.size(), 0);
    check("byte_count_b", rx_count, NFRAMES * FB);
    check("done_count_b", done_count, dones_before + 1);
    check("idle_after_b", {busy, tx}, {1'b0, 1'b1});

    // random dump aborted by reset during the data bits of frame 7
    randomize_inputs();
    load_expected();
    dones_before = done_count;
    pulse_start();
    tick_until_rx(7 * FB + 2, 3000);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    check("abort_outputs", {tx, busy, done, debug_reg_select}, {1'b1, 1'b0, 1'b0, 4'd0});
    tick();
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) tick();
    check("abort_stays_idle", {tx, busy, done}, {1'b1, 1'b0, 1'b0});
    check("abort_no_done", done_count, dones_before);

    // fresh dump after abort restarts from index 0
    randomize_inputs();
    load_expected();
    pulse_start();
    check("restart_select", {busy, debug_reg_select}, {1'b1, 4'd0});
    run_until_done(DUMP_CYCLES + 200, n);
    check("done_latency_d", n + 1, DUMP_CYCLES);
    tick();
    check("after_done_d", {done, busy, tx}, {1'b0, 1'b0, 1'b1});
    check("queue_empty_d", exp_q.size(), 0);
    check("done_count_d", done_count, dones_before + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
